// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC-3 memory interface: FSM states, read-source
// selector and the memory-mapped keyboard/display register addresses.
package lc3_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE,
        RELEASE
    } mem_state_t;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_MAIN,
        SRC_MMIO
    } rd_src_t;

    localparam logic [15:0] KBSR_ADDR  = 16'hFE00;
    localparam logic [15:0] KBDR_ADDR  = 16'hFE02;
    localparam logic [15:0] DSR_ADDR   = 16'hFE04;
    localparam logic [15:0] DDR_ADDR   = 16'hFE06;
    localparam int          STATUS_BIT = 15;

    function automatic logic is_mmio_addr(input logic [15:0] addr);
        return (addr == KBSR_ADDR) || (addr == KBDR_ADDR) ||
               (addr == DSR_ADDR)  || (addr == DDR_ADDR);
    endfunction

endpackage

// File: rtl/lc3_main_memory.sv
// Single-port main memory: synchronous write, registered read that only updates
// when a read is requested; the array starts at zero.
module lc3_main_memory #(
    parameter int    MEM_AWIDTH = 16,
    parameter string INIT_FILE  = ""
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [MEM_AWIDTH-1:0] addr,
    input  logic [15:0]           wdata,
    output logic [15:0]           rdata
);

    localparam int DEPTH = 1 << MEM_AWIDTH;

    logic [15:0] mem [DEPTH];

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 16'h0000;
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[addr] <= wdata;
        if (rd_en) rdata <= mem[addr];
    end

endmodule

// File: rtl/lc3_memory_interface.sv
// LC-3 memory stage: IDLE/BUSY/DONE/RELEASE handshake with configurable latency.
// Define LC3_MMIO_EN to decode the keyboard/display registers at xFE00-xFE06.
module lc3_memory_interface
    import lc3_mem_pkg::*;
#(
    parameter int    MEM_LATENCY = 3,
    parameter int    MEM_AWIDTH  = 16,
    parameter string INIT_FILE   = ""
) (
    input  logic        i_clk,
    input  logic        i_Reset_n,
    input  logic        i_MIO_EN,
    input  logic        i_R_W,
    input  logic [15:0] i_MAR,
    input  logic [15:0] i_MDR,
    output logic        o_Ready_Bit,
    output logic [15:0] o_mem_rdata,
    input  logic        i_kbd_valid,
    input  logic [7:0]  i_kbd_data,
    input  logic        i_disp_ready,
    output logic        o_disp_valid,
    output logic [7:0]  o_disp_data
);

    localparam int               CNT_W    = $clog2(MEM_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    mem_state_t       state, state_next;
    logic [CNT_W-1:0] cnt;
    logic             start, commit;

    logic [15:0] acc_addr, acc_wdata;
    logic        acc_write;
    logic [15:0] cur_addr, cur_wdata;
    logic        cur_write;

    logic        is_mmio, mem_we, mem_re;
    logic [15:0] ram_rdata, mmio_rdata;
    rd_src_t     rd_src;

    always_ff @(posedge i_clk or negedge i_Reset_n) begin
        if (!i_Reset_n) state <= IDLE;
        else            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_MIO_EN) state_next = (MEM_LATENCY == 1) ? DONE : BUSY;
            BUSY:    if (cnt == CNT_ONE) state_next = DONE;
            DONE:    state_next = RELEASE;
            RELEASE: if (!i_MIO_EN) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // commit marks the edge that enters DONE: writes land and read data is captured there.
    always_comb begin
        o_Ready_Bit = (state == DONE);
        start       = (state == IDLE) && i_MIO_EN;
        commit      = (start && (MEM_LATENCY == 1)) ||
                      ((state == BUSY) && (cnt == CNT_ONE));
    end

    always_ff @(posedge i_clk or negedge i_Reset_n) begin
        if (!i_Reset_n)          cnt <= '0;
        else if (start)          cnt <= CNT_LOAD;
        else if (state == BUSY)  cnt <= cnt - CNT_ONE;
    end

    // Access latch carries data only; a reset returns the FSM to IDLE, which discards it.
    always_ff @(posedge i_clk) begin
        if (start) begin
            acc_addr  <= i_MAR;
            acc_wdata <= i_MDR;
            acc_write <= i_R_W;
        end
    end

    // A single-cycle access commits on the sampling edge, before the latch holds anything.
    assign cur_addr  = (state == IDLE) ? i_MAR : acc_addr;
    assign cur_wdata = (state == IDLE) ? i_MDR : acc_wdata;
    assign cur_write = (state == IDLE) ? i_R_W : acc_write;

    assign mem_we = commit &&  cur_write && !is_mmio;
    assign mem_re = commit && !cur_write && !is_mmio;

    lc3_main_memory #(
        .MEM_AWIDTH (MEM_AWIDTH),
        .INIT_FILE  (INIT_FILE)
    ) u_main_memory (
        .clk   (i_clk),
        .wr_en (mem_we),
        .rd_en (mem_re),
        .addr  (cur_addr[MEM_AWIDTH-1:0]),
        .wdata (cur_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge i_clk or negedge i_Reset_n) begin
        if (!i_Reset_n)                 rd_src <= SRC_NONE;
        else if (commit && !cur_write)  rd_src <= is_mmio ? SRC_MMIO : SRC_MAIN;
    end

    always_comb begin
        case (rd_src)
            SRC_MAIN: o_mem_rdata = ram_rdata;
            SRC_MMIO: o_mem_rdata = mmio_rdata;
            default:  o_mem_rdata = '0;
        endcase
    end

`ifdef LC3_MMIO_EN
    logic        kbd_ready, disp_ready_bit;
    logic [7:0]  kbd_char;
    logic        kbdr_read, ddr_write;
    logic [15:0] mmio_rd;

    assign is_mmio   = is_mmio_addr(cur_addr);
    assign kbdr_read = commit && !cur_write && (cur_addr == KBDR_ADDR);
    assign ddr_write = commit &&  cur_write && (cur_addr == DDR_ADDR);

    always_comb begin
        mmio_rd = '0;
        case (cur_addr)
            KBSR_ADDR: mmio_rd[STATUS_BIT] = kbd_ready;
            KBDR_ADDR: mmio_rd[7:0]        = kbd_char;
            DSR_ADDR:  mmio_rd[STATUS_BIT] = disp_ready_bit;
            default:   mmio_rd             = '0;
        endcase
    end

    // A new keystroke beats a KBDR read in the same cycle so the character is never lost.
    always_ff @(posedge i_clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            kbd_ready      <= 1'b0;
            kbd_char       <= '0;
            disp_ready_bit <= 1'b1;
            o_disp_valid   <= 1'b0;
            o_disp_data    <= '0;
            mmio_rdata     <= '0;
        end else begin
            if (i_kbd_valid) begin
                kbd_char  <= i_kbd_data;
                kbd_ready <= 1'b1;
            end else if (kbdr_read) begin
                kbd_ready <= 1'b0;
            end
            if (ddr_write) begin
                disp_ready_bit <= 1'b0;
                o_disp_data    <= cur_wdata[7:0];
            end else if (i_disp_ready) begin
                disp_ready_bit <= 1'b1;
            end
            o_disp_valid <= ddr_write;
            if (commit && !cur_write && is_mmio) mmio_rdata <= mmio_rd;
        end
    end
`else
    logic unused_inputs;

    assign is_mmio       = 1'b0;
    assign mmio_rdata    = '0;
    assign o_disp_valid  = 1'b0;
    assign o_disp_data   = '0;
    assign unused_inputs = ^{i_kbd_valid, i_kbd_data, i_disp_ready, cur_addr};
`endif

endmodule

// File: tb/tb_lc3_memory_interface.sv
// Bench for lc3_memory_interface: timeline model of the access handshake plus
// directed literal checks; also exercises a 1-cycle, 8-bit-address instance.
module tb_lc3_memory_interface;

    localparam int LAT = 3;
`ifdef LC3_MMIO_EN
    localparam bit MMIO = 1'b1;
`else
    localparam bit MMIO = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        a_mio = 0, a_rw = 0, a_kbd_valid = 0, a_disp_ready = 0;
    logic [15:0] a_mar = 0, a_mdr = 0;
    logic [7:0]  a_kbd_data = 0;
    logic        a_ready, a_disp_valid;
    logic [15:0] a_rdata;
    logic [7:0]  a_disp_data;

    logic        b_mio = 0, b_rw = 0;
    logic [15:0] b_mar = 0, b_mdr = 0;
    logic        b_ready, b_disp_valid_unused;
    logic [15:0] b_rdata;
    logic [7:0]  b_disp_data_unused;

    int tests = 0;
    int fails = 0;

    lc3_memory_interface #(.MEM_LATENCY(LAT), .MEM_AWIDTH(16), .INIT_FILE("")) dut (
        .i_clk(clk), .i_Reset_n(rst_n), .i_MIO_EN(a_mio), .i_R_W(a_rw),
        .i_MAR(a_mar), .i_MDR(a_mdr), .o_Ready_Bit(a_ready), .o_mem_rdata(a_rdata),
        .i_kbd_valid(a_kbd_valid), .i_kbd_data(a_kbd_data), .i_disp_ready(a_disp_ready),
        .o_disp_valid(a_disp_valid), .o_disp_data(a_disp_data)
    );

    lc3_memory_interface #(.MEM_LATENCY(1), .MEM_AWIDTH(8), .INIT_FILE("")) dut_small (
        .i_clk(clk), .i_Reset_n(rst_n), .i_MIO_EN(b_mio), .i_R_W(b_rw),
        .i_MAR(b_mar), .i_MDR(b_mdr), .o_Ready_Bit(b_ready), .o_mem_rdata(b_rdata),
        .i_kbd_valid(1'b0), .i_kbd_data(8'h00), .i_disp_ready(1'b0),
        .o_disp_valid(b_disp_valid_unused), .o_disp_data(b_disp_data_unused)
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic bit is_mmio(input logic [15:0] a);
        return MMIO && (a == 16'hFE00 || a == 16'hFE02 || a == 16'hFE04 || a == 16'hFE06);
    endfunction

    // Reference model: an access accepted at edge s completes at edge s+LAT-1 and
    // the ready pulse follows that edge; the next access needs MIO_EN seen low
    // on some edge after the one that leaves the ready cycle.
    int          edge_k = 0;
    bit          m_busy = 0, m_wait_low = 0;
    int          m_start = 0, m_done = -100;
    bit          m_wr = 0;
    logic [15:0] m_addr = 0, m_wd = 0;
    logic [15:0] m_mem [int];
    logic [15:0] m_rdata = 0;
    bit          m_kbsr = 0, m_dsr = 1, m_dv = 0;
    logic [7:0]  m_kbdr = 0, m_dd = 0;

    always @(posedge clk) begin
        bit fire, kb_rd, dd_wr;
        fire = 0; kb_rd = 0; dd_wr = 0;
        edge_k++;
        if (!rst_n) begin
            m_busy = 0; m_wait_low = 0; m_done = -100; m_rdata = 0;
            m_kbsr = 0; m_kbdr = 0; m_dsr = 1; m_dv = 0; m_dd = 0;
        end else begin
            if (m_busy) begin
                if (edge_k == m_start + LAT - 1) fire = 1;
            end else if (m_wait_low) begin
                if (edge_k > m_done + 1 && !a_mio) m_wait_low = 0;
            end else if (a_mio) begin
                m_busy = 1; m_start = edge_k;
                m_wr = a_rw; m_addr = a_mar; m_wd = a_mdr;
                if (LAT == 1) fire = 1;
            end
            if (fire) begin
                m_busy = 0; m_wait_low = 1; m_done = edge_k;
                if (m_wr) begin
                    if (!is_mmio(m_addr)) m_mem[int'(m_addr)] = m_wd;
                    else if (m_addr == 16'hFE06) begin dd_wr = 1; m_dd = m_wd[7:0]; end
                end else if (is_mmio(m_addr)) begin
                    case (m_addr)
                        16'hFE00: m_rdata = {m_kbsr, 15'h0};
                        16'hFE02: m_rdata = {8'h00, m_kbdr};
                        16'hFE04: m_rdata = {m_dsr, 15'h0};
                        default:  m_rdata = 16'h0;
                    endcase
                    kb_rd = (m_addr == 16'hFE02);
                end else begin
                    m_rdata = m_mem.exists(int'(m_addr)) ? m_mem[int'(m_addr)] : 16'h0;
                end
            end
            m_dv = dd_wr;
            if (MMIO) begin
                if (a_kbd_valid) begin m_kbsr = 1; m_kbdr = a_kbd_data; end
                else if (kb_rd) m_kbsr = 0;
                if (dd_wr) m_dsr = 0;
                else if (a_disp_ready) m_dsr = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (edge_k > 0) begin
            chk("ready", {31'h0, a_ready}, {31'h0, (m_done == edge_k)});
            chk("rdata", {16'h0, a_rdata}, {16'h0, m_rdata});
            chk("disp_valid", {31'h0, a_disp_valid}, {31'h0, m_dv});
            chk("disp_data", {24'h0, a_disp_data}, {24'h0, m_dd});
        end
    end

    task automatic access(input bit sel, input bit wr, input logic [15:0] addr,
                          input logic [15:0] wd, output logic [15:0] rd,
                          output int lat, output bit dv, output logic [7:0] dd);
        rd = 16'h0; lat = -1; dv = 0; dd = 8'h0;
        @(negedge clk); #1;
        if (sel) begin b_mio = 1; b_rw = wr; b_mar = addr; b_mdr = wd; end
        else     begin a_mio = 1; a_rw = wr; a_mar = addr; a_mdr = wd; end
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if ((sel ? b_ready : a_ready) === 1'b1) begin
                lat = c;
                rd  = sel ? b_rdata : a_rdata;
                dv  = a_disp_valid;
                dd  = a_disp_data;
                break;
            end
            #1;
            // Changes after the sampling edge must not affect the access.
            if (sel) begin b_mar = 16'($urandom); b_mdr = 16'($urandom); end
            else     begin a_mar = 16'($urandom); a_mdr = 16'($urandom); end
        end
        #1;
        if (sel) b_mio = 0; else a_mio = 0;
        repeat (2) @(posedge clk);
    endtask

    logic [15:0] rd;
    int          lat, cnt;
    bit          dv;
    logic [7:0]  dd;
    logic [15:0] pool [16];

    initial begin
        for (int i = 0; i < 16; i++)
            pool[i] = (i < 8) ? 16'h3000 + 16'(i) : 16'hFE00 + 16'(i - 8);
        repeat (3) @(negedge clk);
        chk("reset_ready", {31'h0, a_ready}, 32'h0);
        chk("reset_rdata", {16'h0, a_rdata}, 32'h0);
        chk("reset_disp_valid", {31'h0, a_disp_valid}, 32'h0);
        #1 rst_n = 1;

        access(0, 1, 16'h3000, 16'h1234, rd, lat, dv, dd);
        chk("write_latency", lat, LAT);
        access(0, 0, 16'h3000, 16'h0000, rd, lat, dv, dd);
        chk("read_latency", lat, LAT);
        chk("read_x3000", {16'h0, rd}, 32'h1234);

        // MIO_EN held high for 10 cycles: one pulse only.
        @(negedge clk); #1;
        a_mio = 1; a_rw = 0; a_mar = 16'h3000;
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (a_ready) cnt++;
        end
        #1 a_mio = 0;
        repeat (2) @(posedge clk);
        chk("held_mio_pulses", cnt, 1);

        // Reset during BUSY of a write: write must be dropped.
        access(0, 1, 16'h3001, 16'hAAAA, rd, lat, dv, dd);
        @(negedge clk); #1;
        a_mio = 1; a_rw = 1; a_mar = 16'h3001; a_mdr = 16'h7777;
        @(negedge clk); #1;
        rst_n = 0; a_mio = 0;
        #1;
        chk("async_reset_rdata", {16'h0, a_rdata}, 32'h0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1;
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (a_ready) cnt++;
        end
        chk("reset_no_ready", cnt, 0);
        access(0, 0, 16'h3001, 16'h0000, rd, lat, dv, dd);
        chk("reset_write_dropped", {16'h0, rd}, 32'h0000AAAA);

        // 1-cycle latency, 8-bit address wrap.
        access(1, 1, 16'h0105, 16'hBEEF, rd, lat, dv, dd);
        chk("small_write_latency", lat, 1);
        access(1, 0, 16'h0005, 16'h0000, rd, lat, dv, dd);
        chk("small_read_latency", lat, 1);
        chk("small_wrap_read", {16'h0, rd}, 32'h0000BEEF);

`ifdef LC3_MMIO_EN
        @(negedge clk); #1;
        a_kbd_valid = 1; a_kbd_data = 8'h41;
        @(negedge clk); #1;
        a_kbd_valid = 0;
        access(0, 0, 16'hFE00, 16'h0, rd, lat, dv, dd);
        chk("kbsr_ready", {16'h0, rd}, 32'h8000);
        access(0, 0, 16'hFE02, 16'h0, rd, lat, dv, dd);
        chk("kbdr_char", {16'h0, rd}, 32'h0041);
        access(0, 0, 16'hFE00, 16'h0, rd, lat, dv, dd);
        chk("kbsr_cleared", {16'h0, rd}, 32'h0000);
        access(0, 1, 16'hFE06, 16'h0042, rd, lat, dv, dd);
        chk("ddr_valid", {31'h0, dv}, 32'h1);
        chk("ddr_data", {24'h0, dd}, 32'h42);
        access(0, 0, 16'hFE04, 16'h0, rd, lat, dv, dd);
        chk("dsr_busy", {16'h0, rd}, 32'h0000);
        @(negedge clk); #1;
        a_disp_ready = 1;
        @(negedge clk); #1;
        a_disp_ready = 0;
        access(0, 0, 16'hFE04, 16'h0, rd, lat, dv, dd);
        chk("dsr_ready", {16'h0, rd}, 32'h8000);
`endif

        for (int i = 0; i < 16; i++)
            access(0, 1, pool[i], 16'hC000 + 16'(i), rd, lat, dv, dd);

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk); #1;
            a_mio        = ($urandom_range(0, 3) != 0);
            a_rw         = 1'($urandom);
            a_mar        = pool[$urandom_range(0, 15)];
            a_mdr        = 16'($urandom);
            a_kbd_valid  = ($urandom_range(0, 7) == 0);
            a_kbd_data   = 8'($urandom);
            a_disp_ready = ($urandom_range(0, 5) == 0);
        end
        @(negedge clk); #1;
        a_mio = 0; a_kbd_valid = 0; a_disp_ready = 0;
        repeat (10) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
